fmul_sched: RTL and testbench
=============================

# fmul_sched

Two-requester scheduler for the shared single-precision multiplier `fmul`, which is combinational and has ports `x1, x2, y, ovf`. Accepts operand pairs from two independent requesters, such as the core FP pipe and the divide/sqrt microsequencer. Arbitrates between them round-robin and issues one operation per cycle into a 2-stage registered wrapper around `fmul`. Returns each result with its requester id and tag on one shared valid/ready output. Also keeps a per-requester sticky overflow flag.

## Interface
- `TAG_W`, 4, width of the opaque per-request tag returned with the result.
- `clk` in 1: the only clock.
- `rstn` in 1: reset, synchronous and active-low.
- `req_valid` in [1:0]: request valid, one bit per requester.
- `req_ready` out [1:0]: request accepted; at most one bit is high per cycle.
- `req_x1` in [1:0][31:0]: first operand per requester (IEEE-754 bits).
- `req_x2` in [1:0][31:0]: second operand per requester.
- `req_tag` in [1:0][TAG_W-1:0]: tag per requester.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_id` out 1: index of the requester that issued the result.
- `out_tag` out TAG_W: tag of that request.
- `out_y` out 32: `fmul` result bits.
- `out_ovf` out 1: `fmul` overflow bit.
- `ovf_sticky` out [1:0]: per-requester sticky overflow flag.
- `ovf_clr` in [1:0]: clears the matching sticky bit.

## Operation
- Pipeline stages:
  - S1 is the operand register: `s1_valid`, id, tag, x1, x2.
  - `fmul` is fed from S1.
  - S2 is the result register: `s2_valid`, id, tag, y, ovf.
  - The output drives directly from S2.
- Advance rules:
  - `s2_load = s1_valid && (!s2_valid || out_ready)`.
  - `s1_free = !s1_valid || !s2_valid || out_ready`.
- Arbiter: a 2-state pointer, LAST0 or LAST1, holding the last granted requester.
  - Exactly one request valid: that requester is granted.
  - Both valid: the requester not equal to LAST wins.
- `req_ready[i] = grant[i] && s1_free && rstn`.
  - `req_ready` may depend on `req_valid`.
  - A combinational path from `out_ready` to `req_ready` is permitted.
- Accept: `req_valid[i] && req_ready[i]`.
  - S1 loads the operands, id and tag.
  - The pointer moves to LAST_i.
  - The pointer changes only on an accept.
- Retire: `out_valid && out_ready`.
  - S2 empties, unless it is reloaded in the same cycle.
- Stall: while `out_valid && !out_ready`, S1 and S2 hold all contents bit-stable.
  - If S1 is also full, both `req_ready` bits are 0.
- Ordering: results leave in acceptance order. No drop, duplication or reordering.
- Reset, synchronous and taking priority over all other activity:
  - `out_valid`, `out_id`, `out_tag`, `out_y`, `out_ovf` and `ovf_sticky` are 0.
  - `req_ready` is 0.
  - The pointer is set to LAST1, so requester 0 wins the first tie.
  - Reset asserted mid-operation discards everything in flight; none of it is ever presented.

## Timing
- Latency:
  - A request accepted at edge N appears on `out_valid` after edge N+1, when the output is not stalled.
  - That result is earliest retireable at edge N+2.
- Throughput is 1 result/cycle with `out_ready` held at 1.
- When both requesters hold valid continuously, grants alternate 0,1,0,1.
- There is no combinational path from `req_*` to `out_*`.

## Configuration
- `FMUL_SCHED_OVF_STICKY_EN` defined:
  - `ovf_sticky[out_id]` sets on retire when `out_ovf` = 1.
  - `ovf_clr[i]` clears bit i.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Undefined:
  - `ovf_sticky` is constant 0.
  - `ovf_clr` is ignored.
  - No sticky flops are present.
- Ports are identical in both builds.

## Structure
- Package `fmul_sched_pkg`:
  - `localparam FP_W = 32`.
  - `typedef logic [FP_W-1:0] fp32_t`.
  - The arbiter pointer enum `rr_last_t {LAST0, LAST1}`.
- Sub-module `fmul_rr_arb2`:
  - Holds the 2-way round-robin grant logic and the pointer register.
  - Inputs: `req_valid`, accept strobe.
  - Output: one-hot grant.
- `fmul` is instantiated unchanged inside `fmul_sched`.

## Test plan
- Single op: requester 0 sends `x1=0x3FC00000`, `x2=0x40000000`, tag 5.
  - Expected: `out_y=0x40400000`, `out_ovf=0`, `out_id=0`, `out_tag=5`.
  - `out_valid` rises one cycle after the accept.
- Overflow: requester 1 sends `0x7F000000 * 0x7F000000`.
  - Expected: `out_y=0x7F800000`, `out_ovf=1`.
  - `ovf_sticky=2'b10` after retire (with the macro); it stays 0 without the macro.
  - Pulsing `ovf_clr[1]` returns the flag to 0.
- Contention: both requesters valid for 8 cycles, `out_ready=1`.
  - Accept ids are 0,1,0,1,…, one per cycle.
  - Results are in order with correct tags.
- Backpressure: with both requesters streaming, `out_ready=0` for 3 cycles.
  - `req_ready=2'b00` once S1 fills.
  - `out_*` is held stable.
  - After release there is no lost or duplicated result; the tag sequence is verified.
- Reset mid-flight: deassert `rstn` for 1 cycle with S1 and S2 full.
  - Next cycle: `out_valid=0`.
  - The flushed ops never appear.
  - The first tie goes to requester 0.
- Sticky race: `ovf_clr[0]=1` in the same cycle as an overflowing retire for requester 0.
  - `ovf_sticky[0]` = 1.

Source files
------------

// File: rtl/fmul_sched_pkg.sv
// Shared types for the fmul scheduler: FP word, arbiter pointer encoding.
// No logic; imported by the interface, arbiter and top.
package fmul_sched_pkg;
    localparam int FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } rr_last_t;
endpackage

// File: rtl/fmul_sched_if.sv
// Requester/result bundle of fmul_sched. The master side drives requests and
// out_ready; the slave side (the scheduler) returns ready and results.
interface fmul_sched_if #(
    parameter int TAG_W = 4
);
    import fmul_sched_pkg::*;

    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    fp32_t [1:0]           req_x1;
    fp32_t [1:0]           req_x2;
    logic [1:0][TAG_W-1:0] req_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_id;
    logic [TAG_W-1:0]      out_tag;
    fp32_t                 out_y;
    logic                  out_ovf;
    logic [1:0]            ovf_sticky;
    logic [1:0]            ovf_clr;

    modport master (
        output req_valid, req_x1, req_x2, req_tag, out_ready, ovf_clr,
        input  req_ready, out_valid, out_id, out_tag, out_y, out_ovf, ovf_sticky
    );

    modport slave (
        input  req_valid, req_x1, req_x2, req_tag, out_ready, ovf_clr,
        output req_ready, out_valid, out_id, out_tag, out_y, out_ovf, ovf_sticky
    );
endinterface

// File: rtl/fmul.sv
// Combinational IEEE-754 single multiply, round-to-nearest-even, denormals flushed to zero.
// ovf flags a finite product whose exponent overflowed to infinity.
module fmul (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic               sgn;
    logic [47:0]        prod;
    logic [22:0]        mant;
    logic               g;
    logic               st;
    logic [23:0]        mrnd;
    logic signed [10:0] exp_s;

    always_comb begin
        ea   = x1[30:23];
        eb   = x2[30:23];
        sgn  = x1[31] ^ x2[31];
        prod = {1'b1, x1[22:0]} * {1'b1, x2[22:0]};
        if (prod[47]) begin
            mant = prod[46:24];
            g    = prod[23];
            st   = |prod[22:0];
        end else begin
            mant = prod[45:23];
            g    = prod[22];
            st   = |prod[21:0];
        end
        mrnd  = {1'b0, mant} + {23'd0, g & (st | mant[0])};
        // Rounding carry-out renormalises; mrnd[22:0] is already zero then.
        exp_s = 11'(ea) + 11'(eb) - 11'sd127 + 11'(prod[47]) + 11'(mrnd[23]);

        y   = 32'd0;
        ovf = 1'b0;
        if (ea == 8'hFF || eb == 8'hFF) begin
            if ((ea == 8'hFF && |x1[22:0]) || (eb == 8'hFF && |x2[22:0]) ||
                ea == 8'h00 || eb == 8'h00)
                y = 32'h7FC0_0000;
            else
                y = {sgn, 8'hFF, 23'd0};
        end else if (ea == 8'h00 || eb == 8'h00) begin
            y = {sgn, 31'd0};
        end else if (exp_s >= 11'sd255) begin
            y   = {sgn, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else if (exp_s <= 11'sd0) begin
            y = {sgn, 31'd0};
        end else begin
            y = {sgn, exp_s[7:0], mrnd[22:0]};
        end
    end
endmodule

// File: rtl/fmul_sched_arb.sv
// Two-way round-robin arbiter; pointer remembers the last granted requester.
// Grant is combinational from req_valid; pointer moves only on accept.
module fmul_rr_arb2
    import fmul_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req_valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);
    rr_last_t last_q;
    rr_last_t last_d;

    always_ff @(posedge clk) begin
        if (!rstn) last_q <= LAST1;
        else       last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (accept_i) last_d = grant_o[1] ? LAST1 : LAST0;
    end

    always_comb begin
        grant_o = 2'b00;
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == LAST0) ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end
endmodule

// File: rtl/fmul_sched.sv
// Round-robin scheduler for two requesters into a 2-stage fmul pipe; result 1 cycle after accept,
// 1 op/cycle; out stall freezes S1/S2 and drops req_ready once S1 is full. Sticky ovf: FMUL_SCHED_OVF_STICKY_EN.
module fmul_sched
    import fmul_sched_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rstn,
    fmul_sched_if.slave bus
);
    logic [1:0]       grant;
    logic             s1_free;
    logic             s2_load;
    logic             accept;
    logic             acc_id;
    logic             retire;

    logic             s1_vld_q, s1_vld_d;
    logic             s1_id_q,  s1_id_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    fp32_t            s1_x1_q,  s1_x1_d;
    fp32_t            s1_x2_q,  s1_x2_d;

    logic             s2_vld_q, s2_vld_d;
    logic             s2_id_q,  s2_id_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    fp32_t            s2_y_q,   s2_y_d;
    logic             s2_ovf_q, s2_ovf_d;

    fp32_t            fm_y;
    logic             fm_ovf;

    assign s1_free       = !s1_vld_q || !s2_vld_q || bus.out_ready;
    assign s2_load       = s1_vld_q && (!s2_vld_q || bus.out_ready);
    assign retire        = s2_vld_q && bus.out_ready;
    assign bus.req_ready = grant & {2{s1_free && rstn}};
    assign accept        = |(bus.req_valid & bus.req_ready);
    assign acc_id        = grant[1];

    fmul_rr_arb2 u_arb (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (bus.req_valid),
        .accept_i    (accept),
        .grant_o     (grant)
    );

    fmul u_fmul (
        .x1  (s1_x1_q),
        .x2  (s1_x2_q),
        .y   (fm_y),
        .ovf (fm_ovf)
    );

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_id_d  = s1_id_q;
        s1_tag_d = s1_tag_q;
        s1_x1_d  = s1_x1_q;
        s1_x2_d  = s1_x2_q;
        if (accept) begin
            s1_vld_d = 1'b1;
            s1_id_d  = acc_id;
            s1_tag_d = bus.req_tag[acc_id];
            s1_x1_d  = bus.req_x1[acc_id];
            s1_x2_d  = bus.req_x2[acc_id];
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end

        s2_vld_d = s2_vld_q;
        s2_id_d  = s2_id_q;
        s2_tag_d = s2_tag_q;
        s2_y_d   = s2_y_q;
        s2_ovf_d = s2_ovf_q;
        if (s2_load) begin
            s2_vld_d = 1'b1;
            s2_id_d  = s1_id_q;
            s2_tag_d = s1_tag_q;
            s2_y_d   = fm_y;
            s2_ovf_d = fm_ovf;
        end else if (retire) begin
            s2_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_vld_q <= 1'b0;
            s1_id_q  <= 1'b0;
            s1_tag_q <= '0;
            s1_x1_q  <= '0;
            s1_x2_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_id_q  <= 1'b0;
            s2_tag_q <= '0;
            s2_y_q   <= '0;
            s2_ovf_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_id_q  <= s1_id_d;
            s1_tag_q <= s1_tag_d;
            s1_x1_q  <= s1_x1_d;
            s1_x2_q  <= s1_x2_d;
            s2_vld_q <= s2_vld_d;
            s2_id_q  <= s2_id_d;
            s2_tag_q <= s2_tag_d;
            s2_y_q   <= s2_y_d;
            s2_ovf_q <= s2_ovf_d;
        end
    end

    assign bus.out_valid = s2_vld_q;
    assign bus.out_id    = s2_id_q;
    assign bus.out_tag   = s2_tag_q;
    assign bus.out_y     = s2_y_q;
    assign bus.out_ovf   = s2_ovf_q;

`ifdef FMUL_SCHED_OVF_STICKY_EN
    logic [1:0] sticky_q, sticky_d;

    // Set is applied after clear so a same-cycle overflow retire wins.
    always_comb begin
        sticky_d = sticky_q & ~bus.ovf_clr;
        if (retire && s2_ovf_q) sticky_d[s2_id_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) sticky_q <= 2'b00;
        else       sticky_q <= sticky_d;
    end

    assign bus.ovf_sticky = sticky_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ^bus.ovf_clr;
    assign bus.ovf_sticky = 2'b00;
`endif
endmodule

// File: tb/tb_fmul_sched.sv
// Bench for fmul_sched: transaction-level scoreboard with a real-arithmetic multiply reference.
`timescale 1ns/1ps
module tb_fmul_sched;
    import fmul_sched_pkg::*;

    typedef struct {
        logic        id;
        logic [3:0]  tag;
        logic [31:0] y;
        logic        ovf;
        bit          vis;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fmul_sched_if #(.TAG_W(4)) bus ();

    fmul_sched #(.TAG_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    exp_t        q[$];
    int          acc_log[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          last_id    = 1;
    logic [1:0]  m_sticky   = 2'b00;
    bit          stall_prev = 0;
    logic [38:0] held;
    logic [3:0]  tagc       = 4'd0;

`ifdef FMUL_SCHED_OVF_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic real to_real(input logic [31:0] a);
        logic [10:0] e;
        e = 11'(a[30:23]) + 11'd896;
        return $bitstoreal({a[31], e, a[22:0], 29'd0});
    endfunction

    // Operands keep at most 12 significant bits so products are exact.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        real         p;
        logic [63:0] d;
        int          fe;
        p  = to_real(a) * to_real(b);
        d  = $realtobits(p);
        fe = int'(d[62:52]) - 896;
        if (fe >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
        return {1'b0, d[63], fe[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r[31]    = 1'($urandom_range(0, 1));
        r[30:23] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(180, 200))
                                               : 8'($urandom_range(64, 191));
        r[22:12] = 11'($urandom);
        r[11:0]  = 12'd0;
        return r;
    endfunction

    task automatic drive(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
        bus.req_valid[i] = v;
        bus.req_x1[i]    = a;
        bus.req_x2[i]    = b;
        bus.req_tag[i]   = t;
    endtask

    task automatic both_rand();
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b1, rand_fp(), rand_fp(), tagc);
            tagc = tagc + 4'd1;
        end
    endtask

    // Observe at negedge, update the model, then advance past the next posedge.
    task automatic cycle();
        logic [1:0]  acc;
        logic [1:0]  set;
        logic [1:0]  exp_rdy;
        logic        w;
        bit          free;
        logic [38:0] cur;
        exp_t        e;
        @(negedge clk);
        if (!rstn) begin
            check("rst_req_ready", bus.req_ready, 2'b00);
            @(posedge clk);
            #1;
            q.delete();
            last_id    = 1;
            m_sticky   = 2'b00;
            stall_prev = 0;
            return;
        end
        cur = {bus.out_valid, bus.out_id, bus.out_tag, bus.out_y, bus.out_ovf};
        check("sticky", bus.ovf_sticky, m_sticky);
        if (q.size() > 0 && q[0].vis)
            check("out_bus", cur, {1'b1, q[0].id, q[0].tag, q[0].y, q[0].ovf});
        else
            check("out_valid", bus.out_valid, 1'b0);
        if (stall_prev) check("stall_hold", cur, held);

        free = (q.size() < 2) || bus.out_ready;
        w = (bus.req_valid == 2'b11) ? (last_id == 0) : bus.req_valid[1];
        exp_rdy = (bus.req_valid != 2'b00 && free) ? (w ? 2'b10 : 2'b01) : 2'b00;
        if (bus.req_valid != 2'b00) check("req_ready", bus.req_ready, exp_rdy);

        set = 2'b00;
        if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            if (q[0].ovf) set[q[0].id] = 1'b1;
            void'(q.pop_front());
        end
        if (STK) m_sticky = (m_sticky & ~bus.ovf_clr) | set;
        if (q.size() > 0) begin
            e     = q[0];
            e.vis = 1;
            q[0]  = e;
        end

        acc = bus.req_valid & bus.req_ready;
        if (acc != 2'b00) begin
            e.id  = acc[1];
            e.tag = bus.req_tag[acc[1]];
            {e.ovf, e.y} = ref_mul(bus.req_x1[acc[1]], bus.req_x2[acc[1]]);
            e.vis = 0;
            q.push_back(e);
            last_id = int'(acc[1]);
            acc_log.push_back(int'(acc[1]));
        end

        stall_prev = bus.out_valid && !bus.out_ready;
        held       = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) cycle();
        cycle();
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn          = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_x1    = '0;
        bus.req_x2    = '0;
        bus.req_tag   = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 2'b00;
        cycle();
        cycle();
        rstn = 1'b1;
        check("reset_state", {bus.out_valid, bus.out_id, bus.out_tag, bus.out_y,
                              bus.out_ovf, bus.ovf_sticky}, 41'd0);

        // Single op: 1.5 * 2.0
        bus.out_ready = 1'b1;
        drive(0, 1'b1, 32'h3FC0_0000, 32'h4000_0000, 4'd5);
        cycle();
        drive(0, 1'b0, 32'h0, 32'h0, 4'd0);
        check("single_lat_early", bus.out_valid, 1'b0);
        cycle();
        check("single_res", {bus.out_valid, bus.out_id, bus.out_tag, bus.out_y, bus.out_ovf},
              {1'b1, 1'b0, 4'd5, 32'h4040_0000, 1'b0});
        cycle();

        // Overflow on requester 1, then clear the sticky flag
        drive(1, 1'b1, 32'h7F00_0000, 32'h7F00_0000, 4'd9);
        cycle();
        drive(1, 1'b0, 32'h0, 32'h0, 4'd0);
        cycle();
        check("ovf_res", {bus.out_valid, bus.out_id, bus.out_tag, bus.out_y, bus.out_ovf},
              {1'b1, 1'b1, 4'd9, 32'h7F80_0000, 1'b1});
        cycle();
        check("ovf_sticky_set", bus.ovf_sticky, {STK, 1'b0});
        bus.ovf_clr = 2'b10;
        cycle();
        bus.ovf_clr = 2'b00;
        check("ovf_sticky_clr", bus.ovf_sticky, 2'b00);

        // Contention: both valid for 8 cycles
        acc_log.delete();
        for (int n = 0; n < 8; n++) begin
            both_rand();
            cycle();
        end
        drain();
        check("contend_cnt", acc_log.size(), 8);
        for (int k = 0; k < 8 && k < acc_log.size(); k++)
            check("contend_id", acc_log[k], k % 2);

        // Backpressure: 3 stalled cycles while both stream
        for (int n = 0; n < 3; n++) begin
            both_rand();
            cycle();
        end
        bus.out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            both_rand();
            cycle();
            check("bp_ready", bus.req_ready, 2'b00);
        end
        bus.out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            both_rand();
            cycle();
        end
        drain();

        // Reset mid-flight with S1 and S2 full
        for (int n = 0; n < 2; n++) begin
            both_rand();
            cycle();
        end
        bus.out_ready = 1'b0;
        both_rand();
        cycle();
        check("pre_rst_full", q.size(), 2);
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        check("mid_rst_out", {bus.out_valid, bus.out_id, bus.out_tag, bus.out_y,
                              bus.out_ovf, bus.ovf_sticky}, 41'd0);
        acc_log.delete();
        bus.out_ready = 1'b1;
        both_rand();
        cycle();
        check("rst_first_tie", (acc_log.size() > 0) ? acc_log[0] : -1, 0);
        drain();

        // Sticky race: clear and overflowing retire for requester 0 on the same edge
        drive(0, 1'b1, 32'h7F00_0000, 32'h7F00_0000, 4'd3);
        cycle();
        drive(0, 1'b0, 32'h0, 32'h0, 4'd0);
        cycle();
        bus.ovf_clr = 2'b01;
        cycle();
        bus.ovf_clr = 2'b00;
        check("sticky_race", bus.ovf_sticky[0], STK);
        bus.ovf_clr = 2'b11;
        cycle();
        bus.ovf_clr = 2'b00;

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 2; i++)
                drive(i, 1'($urandom_range(0, 1)), rand_fp(), rand_fp(), 4'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.ovf_clr   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            cycle();
        end
        bus.ovf_clr = 2'b00;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
